// File: rtl/candy_div_ctrl_pkg.sv
// candy_div_ctrl_pkg
// Shared types and defaults for the divider initiator (candy_div_ctrl).
//   - DIV_DATA_W / DIV_ADDR_W : default operand and register-address widths
//   - div_state_e             : controller state encoding
//   - div_zero_quot()         : quotient returned for a zero divisor (all ones)
package candy_div_ctrl_pkg;

  localparam int DIV_DATA_W = 24;
  localparam int DIV_ADDR_W = 5;

  typedef enum logic [2:0] {
    DC_IDLE  = 3'd0,
    DC_READ  = 3'd1,
    DC_WAIT  = 3'd2,
    DC_WB_Q  = 3'd3,
    DC_WB_R  = 3'd4,
    DC_ANNUL = 3'd5
  } div_state_e;

  // A zero divisor yields an all-ones quotient, independent of signedness.
  function automatic logic [DIV_DATA_W-1:0] div_zero_quot();
    return '1;
  endfunction

endpackage

// File: rtl/candy_div_ctrl.sv
// candy_div_ctrl
// Initiator side of the divider start/annul/ready handshake. Takes one DIV
// request from decode, reads both operands from the register file, runs the
// divider, then writes the quotient to rd and the remainder to rd+1.
// Ports:
//   clk, rst                      clock / async active-high reset
//   req_valid_i, req_ready_o      request handshake (ready only in IDLE)
//   req_signed_i, req_rs_i,
//   req_rt_i, req_rd_i            request fields, latched on accept
//   flush_i                       cancel (ignored once writeback starts)
//   busy_o                        high whenever not IDLE
//   re1_o/raddr1_o/rdata1_i       regfile read port 1 (dividend)
//   re2_o/raddr2_o/rdata2_i       regfile read port 2 (divisor)
//   div_signed_o, div_op1_o,
//   div_op2_o, div_start_o,
//   div_annul_o                   to divider
//   div_quot_i, div_rem_i,
//   div_ready_i                   from divider
//   we_o/waddr_o/wdata_o          regfile write port
module candy_div_ctrl
  import candy_div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int ADDR_W = DIV_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_rs_i,
  input  logic [ADDR_W-1:0] req_rt_i,
  input  logic [ADDR_W-1:0] req_rd_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              re1_o,
  output logic [ADDR_W-1:0] raddr1_o,
  input  logic [DATA_W-1:0] rdata1_i,
  output logic              re2_o,
  output logic [ADDR_W-1:0] raddr2_o,
  input  logic [DATA_W-1:0] rdata2_i,
  output logic              div_signed_o,
  output logic [DATA_W-1:0] div_op1_o,
  output logic [DATA_W-1:0] div_op2_o,
  output logic              div_start_o,
  output logic              div_annul_o,
  input  logic [DATA_W-1:0] div_quot_i,
  input  logic [DATA_W-1:0] div_rem_i,
  input  logic              div_ready_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  div_state_e        state;
  logic              sgn_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] rem_q;
  logic [ADDR_W-1:0] rd_nxt;

  // Remainder destination wraps modulo the register count.
  assign rd_nxt = rd_q + ADDR_W'(1);

  // Only combinational output: lets decode see a flush/reset in the same cycle.
  assign req_ready_o = (state == DC_IDLE) & ~flush_i & ~rst;
  assign busy_o      = (state != DC_IDLE);

  // All other outputs are registers loaded with the values belonging to the
  // state being entered, so they change exactly on the state edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DC_IDLE;
      sgn_q        <= 1'b0;
      rd_q         <= '0;
      rem_q        <= '0;
      re1_o        <= 1'b0;
      re2_o        <= 1'b0;
      raddr1_o     <= '0;
      raddr2_o     <= '0;
      div_signed_o <= 1'b0;
      div_op1_o    <= '0;
      div_op2_o    <= '0;
      div_start_o  <= 1'b0;
      div_annul_o  <= 1'b0;
      we_o         <= 1'b0;
      waddr_o      <= '0;
      wdata_o      <= '0;
    end else begin
      // Single-cycle strobes default low; the case below re-asserts them.
      re1_o       <= 1'b0;
      re2_o       <= 1'b0;
      raddr1_o    <= '0;
      raddr2_o    <= '0;
      div_start_o <= 1'b0;
      div_annul_o <= 1'b0;
      we_o        <= 1'b0;
      waddr_o     <= '0;
      wdata_o     <= '0;
      case (state)
        DC_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            state    <= DC_READ;
            sgn_q    <= req_signed_i;
            rd_q     <= req_rd_i;
            re1_o    <= 1'b1;
            re2_o    <= 1'b1;
            raddr1_o <= req_rs_i;
            raddr2_o <= req_rt_i;
          end
        end
        DC_READ: begin
          if (flush_i) begin
            state <= DC_IDLE;
          end else begin
            div_op1_o <= rdata1_i;
            div_op2_o <= rdata2_i;
            if (rdata2_i == '0) begin
              // Zero divisor: result is known now, bypass the divider.
              state   <= DC_WB_Q;
              rem_q   <= rdata1_i;
              we_o    <= (rd_q != '0);
              waddr_o <= rd_q;
              wdata_o <= DATA_W'(div_zero_quot());
            end else begin
              state        <= DC_WAIT;
              div_signed_o <= sgn_q;
              div_start_o  <= 1'b1;
            end
          end
        end
        DC_WAIT: begin
          // Flush has priority over a simultaneous ready.
          if (flush_i) begin
            state       <= DC_ANNUL;
            div_annul_o <= 1'b1;
          end else if (div_ready_i) begin
            state   <= DC_WB_Q;
            rem_q   <= div_rem_i;
            we_o    <= (rd_q != '0);
            waddr_o <= rd_q;
            wdata_o <= div_quot_i;
          end else begin
            div_start_o <= 1'b1;
          end
        end
        DC_WB_Q: begin
          state   <= DC_WB_R;
          we_o    <= (rd_nxt != '0);
          waddr_o <= rd_nxt;
          wdata_o <= rem_q;
        end
        DC_WB_R:  state <= DC_IDLE;
        DC_ANNUL: state <= DC_IDLE;
        default:  state <= DC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_candy_div_ctrl.sv
module tb_candy_div_ctrl;

  localparam int DW = 24;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          req_valid, req_ready, req_signed;
  logic [AW-1:0] req_rs, req_rt, req_rd;
  logic          flush, busy;
  logic          re1, re2;
  logic [AW-1:0] raddr1, raddr2;
  logic [DW-1:0] rdata1, rdata2;
  logic          div_signed, div_start, div_annul;
  logic [DW-1:0] div_op1, div_op2, div_quot, div_rem;
  logic          div_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  candy_div_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_signed_i(req_signed),
    .req_rs_i(req_rs), .req_rt_i(req_rt), .req_rd_i(req_rd),
    .flush_i(flush), .busy_o(busy),
    .re1_o(re1), .raddr1_o(raddr1), .rdata1_i(rdata1),
    .re2_o(re2), .raddr2_o(raddr2), .rdata2_i(rdata2),
    .div_signed_o(div_signed), .div_op1_o(div_op1), .div_op2_o(div_op2),
    .div_start_o(div_start), .div_annul_o(div_annul),
    .div_quot_i(div_quot), .div_rem_i(div_rem), .div_ready_i(div_ready),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: r0 reads zero, combinational reads.
  logic [DW-1:0] rf [32];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  assign rdata1 = (raddr1 == '0) ? '0 : rf[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : rf[raddr2];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    if (we && waddr != '0) rf[waddr] <= wdata;
  end

  // Divider model: ready pulses after lat cycles of start.
  int lat;
  int dcnt;
  logic signed [DW-1:0] s1, s2;
  assign s1 = div_op1;
  assign s2 = div_op2;
  always @(posedge clk or posedge rst) begin
    if (rst || div_annul) begin
      dcnt <= 0; div_ready <= 1'b0; div_quot <= '0; div_rem <= '0;
    end else if (div_start && !div_ready) begin
      if (dcnt == lat - 1) begin
        div_ready <= 1'b1;
        dcnt      <= 0;
        if (div_signed) begin
          div_quot <= s1 / s2;
          div_rem  <= s1 % s2;
        end else begin
          div_quot <= div_op1 / div_op2;
          div_rem  <= div_op1 % div_op2;
        end
      end else dcnt <= dcnt + 1;
    end else div_ready <= 1'b0;
  end

  // Activity monitors, sampled mid-cycle.
  int st_cnt = 0, an_cnt = 0, we_cnt = 0, we0_cnt = 0, bz_cnt = 0, ov_cnt = 0;
  logic wb31_prev = 1'b0, r0_busy = 1'b0, r0_we = 1'b1;
  always @(negedge clk) begin
    if (div_start) st_cnt++;
    if (div_annul) an_cnt++;
    if (busy) bz_cnt++;
    if (we) begin we_cnt++; if (waddr == '0) we0_cnt++; end
    if (div_start && we) ov_cnt++;
    if (wb31_prev) begin r0_busy = busy; r0_we = we; end
    wb31_prev = we && (waddr == 5'd31);
  end

  logic any_out;
  assign any_out = |{req_ready, busy, re1, re2, raddr1, raddr2, div_signed, div_op1,
                     div_op2, div_start, div_annul, we, waddr, wdata};

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic sg, input logic [AW-1:0] rs, rt, rd);
    @(negedge clk);
    req_valid = 1'b1; req_signed = sg; req_rs = rs; req_rt = rt; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 50);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!div_start && n < 20) begin @(negedge clk); n++; end
    chk(tag, 32'(div_start), 32'd1);
  endtask

  int st0, bz0, we0, an0, w00;
  task automatic snap();
    st0 = st_cnt; bz0 = bz_cnt; we0 = we_cnt; an0 = an_cnt; w00 = we0_cnt;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_rs = '0; req_rt = '0;
    req_rd = '0; flush = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0; lat = 3;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", 32'(any_out), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_ready", 32'(req_ready), 32'd1);

    // Unsigned 100/7
    preload(5'd1, 24'd100); preload(5'd2, 24'd7);
    snap(); do_req(1'b0, 5'd1, 5'd2, 5'd5); wait_idle("u_idle");
    chk("u_quot", 32'(rf[5]), 32'd14);
    chk("u_rem", 32'(rf[6]), 32'd2);
    chk("u_start_cycles", 32'(st_cnt - st0), 32'd4);
    chk("u_busy_cycles", 32'(bz_cnt - bz0), 32'd7);
    chk("u_start_in_wb", 32'(ov_cnt), 32'd0);
    chk("u_ready_back", 32'(req_ready), 32'd1);

    // Signed -7/2
    preload(5'd1, 24'hFFFFF9); preload(5'd2, 24'd2);
    do_req(1'b1, 5'd1, 5'd2, 5'd8); wait_idle("s_idle");
    chk("s_quot", 32'(rf[8]), 32'h00FFFFFD);
    chk("s_rem", 32'(rf[9]), 32'h00FFFFFF);

    // Divide by zero
    preload(5'd1, 24'h000123); preload(5'd2, 24'd0);
    snap(); do_req(1'b0, 5'd1, 5'd2, 5'd3); wait_idle("z_idle");
    chk("z_quot", 32'(rf[3]), 32'h00FFFFFF);
    chk("z_rem", 32'(rf[4]), 32'h00000123);
    chk("z_no_start", 32'(st_cnt - st0), 32'd0);
    chk("z_busy_cycles", 32'(bz_cnt - bz0), 32'd3);

    // Flush in the third WAIT cycle
    lat = 6;
    preload(5'd1, 24'd500); preload(5'd2, 24'd5);
    preload(5'd16, 24'hABCDEF); preload(5'd17, 24'h123456);
    snap(); do_req(1'b0, 5'd1, 5'd2, 5'd16);
    wait_start("f_start");
    @(negedge clk); @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    chk("f_annul", 32'(div_annul), 32'd1);
    chk("f_annul_start", 32'(div_start), 32'd0);
    chk("f_annul_ready", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("f_annul_drop", 32'(div_annul), 32'd0);
    chk("f_ready_back", 32'(req_ready), 32'd1);
    chk("f_annul_cycles", 32'(an_cnt - an0), 32'd1);
    chk("f_no_writes", 32'(we_cnt - we0), 32'd0);
    chk("f_rd_kept", 32'(rf[16]), 32'h00ABCDEF);
    chk("f_rd1_kept", 32'(rf[17]), 32'h00123456);

    // Flush in READ
    lat = 3;
    preload(5'd18, 24'h000055);
    snap(); do_req(1'b0, 5'd1, 5'd2, 5'd18);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    @(negedge clk);
    chk("fr_idle", 32'(busy), 32'd0);
    chk("fr_no_start", 32'(st_cnt - st0), 32'd0);
    chk("fr_no_writes", 32'(we_cnt - we0), 32'd0);
    chk("fr_rd_kept", 32'(rf[18]), 32'h00000055);

    // rd=31: remainder would target r0
    preload(5'd10, 24'd50); preload(5'd11, 24'd6);
    snap(); do_req(1'b0, 5'd10, 5'd11, 5'd31); wait_idle("r31_idle");
    chk("r31_quot", 32'(rf[31]), 32'd8);
    chk("r31_no_r0_write", 32'(we0_cnt - w00), 32'd0);
    chk("r31_wbr_busy", 32'(r0_busy), 32'd1);
    chk("r31_wbr_we", 32'(r0_we), 32'd0);

    // Reset mid-WAIT, then a clean request
    lat = 6;
    preload(5'd12, 24'd1000); preload(5'd13, 24'd33);
    do_req(1'b0, 5'd12, 5'd13, 5'd20);
    wait_start("rw_start");
    rst = 1'b1; #1;
    chk("rw_outs", 32'(any_out), 32'd0);
    chk("rw_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b0; lat = 3;
    do_req(1'b0, 5'd12, 5'd13, 5'd20); wait_idle("rw_idle");
    chk("rw_quot", 32'(rf[20]), 32'd30);
    chk("rw_rem", 32'(rf[21]), 32'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
